seq_detect_arbiter: RTL and testbench
=====================================

// Module: seq_detect_arbiter
// PURPOSE
//  Shares one serial "101" Moore pattern-detector core between NREQ requesters.
//  Each requester hands over one WORD_W-bit word; the block serialises it MSB-first
//  into the core and counts overlapping matches. It returns count + requester id.
//  Sits between parallel producers and the serial detector; one word in flight at a time.
// PARAMETERS
//  NREQ    2       number of requesters (>=2)
//  WORD_W  8       bits per request word (>=3)
//  PATTERN 3'b101  3-bit pattern detected, first-received bit = PATTERN[2]
//  CNT_W   $clog2(WORD_W-1)  match-count width (max count = WORD_W-2)
//  ID_W    $clog2(NREQ)      requester id width
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            asynchronous, active-high reset
//  req_valid  in   NREQ         per-requester word valid
//  req_data   in   NREQ*WORD_W  word of requester i at [i*WORD_W +: WORD_W]
//  req_ready  out  NREQ         one-hot grant/accept, IDLE only
//  rsp_valid  out  1            result available; held until rsp_ready
//  rsp_ready  in   1            consumer accepts result
//  rsp_id     out  ID_W         requester that owned the word
//  rsp_count  out  CNT_W        number of matches in the word, overlaps counted
//  rsp_any    out  1            rsp_count != 0
//  busy       out  1            high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, rsp_any=0, busy=0.
//  FSM IDLE -> SHIFT -> FLUSH -> REPORT -> IDLE.
//  IDLE: the winner is the first req_valid at or after the rr pointer, wrapping.
//   req_ready[winner]=1 combinationally, all other bits 0.
//   On the edge, capture the word, the id, clear the core history and count, then go to SHIFT.
//   With no req_valid, stay in IDLE.
//  SHIFT: exactly WORD_W cycles, one bit per cycle, MSB first. Bit index counter runs WORD_W-1..0.
//   The core is a Moore FSM; its match output reflects the bit shifted one cycle earlier.
//   Count increments when the core match output is 1. Saturation is unnecessary by CNT_W sizing.
//  FLUSH: 1 cycle that absorbs the match from the last bit, then go to REPORT.
//  REPORT: rsp_valid=1, with rsp_id, rsp_count and rsp_any stable.
//   On rsp_valid&rsp_ready: rr pointer = rsp_id+1 (mod NREQ), then go to IDLE.
//  Latency: accept edge to rsp_valid high = WORD_W+2 cycles. Min issue interval = WORD_W+3 cycles.
//  The history is cleared per word, so a match never spans two words.
//   Matches need >=3 bits of the current word.
//  A req_valid drop while not granted has no effect. req_data is sampled only on the accept edge.
//  rsp_ready has no effect outside REPORT. If rsp_ready=1 in the first REPORT cycle, it completes that cycle.
//  Reset at any time: abort the in-flight word silently (no rsp) and return to the reset values.
// STRUCTURE
//  Package seq_detect_pkg: FSM state enum (IDLE, SHIFT, FLUSH, REPORT).
//   It also holds the core state encodings S_0..S_7 and the default PATTERN constant.
//  Sub-module pattern_detect_core: 8-state Moore FSM with ports clk, reset, clr, bit_in, bit_en, match.
//   Next-state is combinational, the state register is non-blocking, and the case has a default.
//  Top: round-robin select, shift register, bit counter, match counter, control FSM.
// TESTING (WORD_W=8, NREQ=2)
//  req0 data 8'b10101010 -> rsp_id=0, rsp_count=3, rsp_any=1, rsp_valid exactly 10 cycles after accept.
//  req1 8'b10110101 -> count 3; 8'h00 -> count 0, any=0; 8'hFF -> count 0.
//  Both req_valid held from reset release -> grant order 0,1,0,1; each req_ready pulse lasts 1 cycle.
//  Word A=8'bxxxxxx10, then word B=8'b1xxxxxxx with no 101 inside either -> count 0 (no cross-word match).
//  rsp_ready low for 5 cycles in REPORT -> outputs stable, req_ready stays 0, busy=1. The accept after it returns to IDLE.
//  reset pulsed at SHIFT bit 4 -> rsp_valid=0, busy=0 immediately. The next grant goes to req0.

Source files
------------

// File: rtl/seq_detect_arbiter_pkg.sv
// Shared types for the "101" detector arbiter: control FSM states,
// detector core state encodings and the default pattern.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } ctrl_state_e;

  // Core state = last three bits received, oldest in bit 2.
  localparam logic [2:0] S_0 = 3'd0;
  localparam logic [2:0] S_1 = 3'd1;
  localparam logic [2:0] S_2 = 3'd2;
  localparam logic [2:0] S_3 = 3'd3;
  localparam logic [2:0] S_4 = 3'd4;
  localparam logic [2:0] S_5 = 3'd5;
  localparam logic [2:0] S_6 = 3'd6;
  localparam logic [2:0] S_7 = 3'd7;

  localparam logic [2:0] DEF_PATTERN = 3'b101;

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// Request/response bundle of seq_detect_arbiter.
// master = producers/consumer side, slave = the arbiter.
interface seq_detect_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int WORD_W = 8,
  parameter int CNT_W  = $clog2(WORD_W-1),
  parameter int ID_W   = $clog2(NREQ)
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WORD_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [CNT_W-1:0]       rsp_count;
  logic                   rsp_any;
  logic                   busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_count, rsp_any, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_count, rsp_any, busy
  );
endinterface

// File: rtl/seq_detect_arbiter_core.sv
// Moore 3-bit pattern detector: clk, reset, clr (history wipe),
// bit_in/bit_en (serial input), match (registered state hits PATTERN).
module pattern_detect_core
  import seq_detect_pkg::*;
#(
  parameter logic [2:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_in,
  input  logic bit_en,
  output logic match
);

  logic [2:0] state_q, state_d;
  // Bits seen since clr, saturating at 3; blocks matches on a
  // partially filled history.
  logic [1:0] fill_q, fill_d;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (clr) begin
      state_d = S_0;
      fill_d  = 2'd0;
    end else if (bit_en) begin
      case (state_q)
        S_0, S_4: state_d = bit_in ? S_1 : S_0;
        S_1, S_5: state_d = bit_in ? S_3 : S_2;
        S_2, S_6: state_d = bit_in ? S_5 : S_4;
        S_3, S_7: state_d = bit_in ? S_7 : S_6;
        default:  state_d = S_0;
      endcase
      if (fill_q != 2'd3)
        fill_d = fill_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_0;
      fill_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  assign match = (fill_q == 2'd3) && (state_q == PATTERN);

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin shares one serial pattern detector among NREQ requesters.
// Ports: clk, reset, bus (slave: req_*, rsp_*, busy).
module seq_detect_arbiter
  import seq_detect_pkg::*;
#(
  parameter int         NREQ    = 2,
  parameter int         WORD_W  = 8,
  parameter logic [2:0] PATTERN = DEF_PATTERN,
  parameter int         CNT_W   = $clog2(WORD_W-1),
  parameter int         ID_W    = $clog2(NREQ)
) (
  input logic                clk,
  input logic                reset,
  seq_detect_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(WORD_W);

  ctrl_state_e       state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [WORD_W-1:0] win_word;
  logic [NREQ-1:0]   ready_c;
  logic              clr;
  logic              bit_en;
  logic              match;

  pattern_detect_core #(
    .PATTERN (PATTERN)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .bit_in (word_q[WORD_W-1]),
    .bit_en (bit_en),
    .match  (match)
  );

  // First valid at or after rr pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_word  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found &&
          bus.req_valid[(int'(rr_q) + i) % NREQ]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(rr_q) + i) % NREQ);
        win_word  = bus.req_data[
          ((int'(rr_q) + i) % NREQ) * WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    word_d  = word_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    ready_c = '0;
    clr     = 1'b0;
    bit_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          ready_c[win_id] = 1'b1;
          word_d  = win_word;
          id_d    = win_id;
          cnt_d   = '0;
          bit_d   = IDX_W'(WORD_W-1);
          clr     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bit_en = 1'b1;
        word_d = {word_q[WORD_W-2:0], 1'b0};
        // match lags the shifted bit by one cycle
        if (match)
          cnt_d = cnt_q + CNT_W'(1);
        if (bit_q == '0)
          state_d = FLUSH;
        else
          bit_d = bit_q - IDX_W'(1);
      end
      FLUSH: begin
        if (match)
          cnt_d = cnt_q + CNT_W'(1);
        state_d = REPORT;
      end
      REPORT: begin
        if (bus.rsp_ready) begin
          rr_d = (id_q == ID_W'(NREQ-1)) ?
                 '0 : id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = (state_q == REPORT);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_count = cnt_q;
  assign bus.rsp_any   = |cnt_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed bench for seq_detect_arbiter (NREQ=2, WORD_W=8).
// Hand-computed match counts, grant order, stall and reset abort.
module tb_seq_detect_arbiter;

  localparam int NREQ   = 2;
  localparam int WORD_W = 8;
  localparam int CNT_W  = $clog2(WORD_W-1);
  localparam int ID_W   = $clog2(NREQ);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_detect_arbiter_if #(
    .NREQ(NREQ), .WORD_W(WORD_W),
    .CNT_W(CNT_W), .ID_W(ID_W)
  ) bus ();

  seq_detect_arbiter #(
    .NREQ(NREQ), .WORD_W(WORD_W),
    .PATTERN(3'b101)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Ticks until rsp_valid; n counts cycles from the accept cycle.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_rsp;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_word(input int r,
                         input logic [7:0] d,
                         input int exp_cnt,
                         input string tag);
    int n;
    bus.req_valid = '0;
    bus.req_valid[r] = 1'b1;
    bus.req_data[r*WORD_W +: WORD_W] = d;
    #1;
    check({tag, " ready"}, 32'(bus.req_ready), 32'(1 << r));
    tick();
    bus.req_valid = '0;
    bus.req_data  = '1;
    wait_rsp(n);
    check({tag, " latency"}, n, 10);
    check({tag, " id"}, 32'(bus.rsp_id), r);
    check({tag, " count"}, 32'(bus.rsp_count), exp_cnt);
    check({tag, " any"}, 32'(bus.rsp_any), 32'(exp_cnt != 0));
    finish_rsp();
    check({tag, " idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int n;
    int e;
    logic [CNT_W-1:0] cnt_hold;

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check("rst ready", 32'(bus.req_ready), 0);
    check("rst valid", 32'(bus.rsp_valid), 0);
    check("rst id", 32'(bus.rsp_id), 0);
    check("rst count", 32'(bus.rsp_count), 0);
    check("rst any", 32'(bus.rsp_any), 0);
    check("rst busy", 32'(bus.busy), 0);
    reset = 1'b0;
    tick();

    do_word(0, 8'b10101010, 3, "w_aa");
    do_word(1, 8'b10110101, 3, "w_b5");
    do_word(0, 8'h00, 0, "w_00");
    do_word(1, 8'hFF, 0, "w_ff");
    do_word(0, 8'b00000101, 1, "w_tail");
    do_word(1, 8'b10100000, 1, "w_head");
    do_word(0, 8'b10100101, 2, "w_a5");
    do_word(0, 8'b00000010, 0, "w_xa");
    do_word(0, 8'b10000000, 0, "w_xb");

    // both requesters held from reset release
    reset = 1'b1;
    tick();
    bus.req_data = {8'h00, 8'b10101010};
    bus.req_valid = 2'b11;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = k % 2;
      check("rr grant", 32'(bus.req_ready), 32'(1 << e));
      tick();
      check("rr pulse", 32'(bus.req_ready), 0);
      wait_rsp(n);
      check("rr latency", n, 10);
      check("rr id", 32'(bus.rsp_id), e);
      check("rr count", 32'(bus.rsp_count),
            (e == 0) ? 3 : 0);
      finish_rsp();
    end

    // stalled response, requests still pending
    check("stall grant", 32'(bus.req_ready), 1);
    tick();
    wait_rsp(n);
    cnt_hold = bus.rsp_count;
    check("stall cnt", 32'(cnt_hold), 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall valid", 32'(bus.rsp_valid), 1);
      check("stall count", 32'(bus.rsp_count), 3);
      check("stall id", 32'(bus.rsp_id), 0);
      check("stall ready", 32'(bus.req_ready), 0);
      check("stall busy", 32'(bus.busy), 1);
    end
    finish_rsp();
    check("post valid", 32'(bus.rsp_valid), 0);
    check("post busy", 32'(bus.busy), 0);
    check("post grant", 32'(bus.req_ready), 2);

    // reset mid-word: accept req1, abort at bit 4
    tick();
    tick();
    tick();
    tick();
    check("mid busy", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check("abort valid", 32'(bus.rsp_valid), 0);
    check("abort busy", 32'(bus.busy), 0);
    check("abort count", 32'(bus.rsp_count), 0);
    tick();
    reset = 1'b0;
    #1;
    check("abort grant", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = '0;
    wait_rsp(n);
    check("abort id", 32'(bus.rsp_id), 0);
    check("abort wcount", 32'(bus.rsp_count), 3);
    finish_rsp();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
